// File: rtl/db_pkg.sv
// -----------------------------------------------------------------------------
// db_pkg
// Shared definitions for the switch debouncer and its event detector.
//   db_evt_state_t  : press-tracking FSM states of db_event_detect
//   LONG_TICKS_DEF  : default number of m_tick strobes that make a long press
//   CNT_W_DEF       : default width of the press/long event counters
// -----------------------------------------------------------------------------
package db_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG
    } db_evt_state_t;

    localparam int LONG_TICKS_DEF = 16;
    localparam int CNT_W_DEF      = 8;

endpackage : db_pkg

// File: rtl/db_event_detect_if.sv
// -----------------------------------------------------------------------------
// db_event_detect_if
// Groups the signals between the debouncer side and db_event_detect.
//   db_i         : debounced switch level
//   m_tick_i     : one-cycle tick strobe from the debouncer
//   clr_cnt_i    : synchronous clear of both event counters
//   rise_tick_o  : one-cycle press pulse
//   fall_tick_o  : one-cycle release pulse
//   long_press_o : one-cycle pulse when the hold threshold is reached
//   held_o       : high while a press is in progress
//   press_cnt_o  : saturating count of short presses
//   long_cnt_o   : saturating count of long presses
// Modports: master drives the inputs and observes results, slave is the
// event detector itself.
// -----------------------------------------------------------------------------
interface db_event_detect_if #(
    parameter int CNT_W = db_pkg::CNT_W_DEF
) ();

    logic             db_i;
    logic             m_tick_i;
    logic             clr_cnt_i;
    logic             rise_tick_o;
    logic             fall_tick_o;
    logic             long_press_o;
    logic             held_o;
    logic [CNT_W-1:0] press_cnt_o;
    logic [CNT_W-1:0] long_cnt_o;

    modport master (
        output db_i, m_tick_i, clr_cnt_i,
        input  rise_tick_o, fall_tick_o, long_press_o, held_o,
               press_cnt_o, long_cnt_o
    );

    modport slave (
        input  db_i, m_tick_i, clr_cnt_i,
        output rise_tick_o, fall_tick_o, long_press_o, held_o,
               press_cnt_o, long_cnt_o
    );

endinterface : db_event_detect_if

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Event counter that sticks at all-ones instead of wrapping. A clear in the
// same cycle as an increment wins, so that event is dropped.
//   clk     : system clock
//   reset   : asynchronous active-low reset
//   inc_i   : count one event
//   clr_i   : synchronous clear to zero
//   count_o : registered count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // NOTE: assigning the default first keeps every path covered, so no latch
    // is inferred.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its inputs from before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : sat_counter

// File: rtl/db_event_detect.sv
// -----------------------------------------------------------------------------
// db_event_detect
// Turns the debounced level into press/release events, classifies each press
// as short or long by counting debouncer ticks while held, and keeps
// saturating counts of both kinds. Every output is registered.
//   clk    : system clock, shared with the debouncer
//   reset  : asynchronous active-low reset
//   bus    : db_event_detect_if.slave (see interface header for signals)
// Parameters:
//   LONG_TICKS : m_tick strobes of continuous hold that make a long press (>=2)
//   CNT_W      : width of the event counters
//   HOLD_W     : width of the hold counter, derived from LONG_TICKS
// -----------------------------------------------------------------------------
module db_event_detect
    import db_pkg::*;
#(
    parameter int LONG_TICKS = LONG_TICKS_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int HOLD_W     = $clog2(LONG_TICKS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    db_event_detect_if.slave   bus
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);

    db_evt_state_t     state_q, state_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;
    logic              db_q;
    logic              rise_q,  rise_d;
    logic              fall_q,  fall_d;
    logic              long_q,  long_d;
    logic              held_q,  held_d;
    logic              press_inc;
    logic              long_inc;
    logic              rise_edge;
    logic              fall_edge;

    assign rise_edge =  bus.db_i & ~db_q;
    assign fall_edge = ~bus.db_i &  db_q;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        long_d    = 1'b0;
        press_inc = 1'b0;
        long_inc  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rise_edge) begin
                    state_d = PRESSED;
                    hold_d  = '0;
                    rise_d  = 1'b1;
                end
            end
            PRESSED: begin
                // A release on the same cycle as the threshold tick wins:
                // the press is counted as short.
                if (fall_edge) begin
                    state_d   = IDLE;
                    fall_d    = 1'b1;
                    press_inc = 1'b1;
                end else if (bus.m_tick_i) begin
                    hold_d = hold_q + 1'b1;
                    if (hold_q == HOLD_LAST) begin
                        state_d  = LONG;
                        long_d   = 1'b1;
                        long_inc = 1'b1;
                    end
                end
            end
            LONG: begin
                if (fall_edge) begin
                    state_d = IDLE;
                    fall_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        held_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            long_q  <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            db_q    <= bus.db_i;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            long_q  <= long_d;
            held_q  <= held_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_press_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (press_inc),
        .clr_i   (bus.clr_cnt_i),
        .count_o (bus.press_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_long_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (long_inc),
        .clr_i   (bus.clr_cnt_i),
        .count_o (bus.long_cnt_o)
    );

    assign bus.rise_tick_o  = rise_q;
    assign bus.fall_tick_o  = fall_q;
    assign bus.long_press_o = long_q;
    assign bus.held_o       = held_q;

endmodule : db_event_detect

// File: tb/tb_db_event_detect.sv
// -----------------------------------------------------------------------------
// tb_db_event_detect
// Directed bench for db_event_detect with LONG_TICKS=4, CNT_W=4.
// -----------------------------------------------------------------------------
module tb_db_event_detect;

    localparam int LT = 4;
    localparam int CW = 4;

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;

    // Pulse tallies, sampled on the falling edge.
    int rise_seen = 0;
    int fall_seen = 0;
    int long_seen = 0;

    db_event_detect_if #(.CNT_W(CW)) bus ();

    db_event_detect #(
        .LONG_TICKS (LT),
        .CNT_W      (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset) begin
            rise_seen <= rise_seen + int'(bus.rise_tick_o);
            fall_seen <= fall_seen + int'(bus.fall_tick_o);
            long_seen <= long_seen + int'(bus.long_press_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bus.m_tick_i = 1'b1;
        step();
        bus.m_tick_i = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic r, input logic f,
                              input logic l, input logic h,
                              input int pc, input int lc);
        check({tag, ".rise"},  32'(bus.rise_tick_o),  32'(r));
        check({tag, ".fall"},  32'(bus.fall_tick_o),  32'(f));
        check({tag, ".long"},  32'(bus.long_press_o), 32'(l));
        check({tag, ".held"},  32'(bus.held_o),       32'(h));
        check({tag, ".pcnt"},  32'(bus.press_cnt_o),  32'(pc));
        check({tag, ".lcnt"},  32'(bus.long_cnt_o),   32'(lc));
    endtask

    task automatic clear_counters();
        bus.clr_cnt_i = 1'b1;
        step();
        bus.clr_cnt_i = 1'b0;
    endtask

    initial begin
        int r0, f0, l0;

        reset         = 1'b0;
        bus.db_i      = 1'b0;
        bus.m_tick_i  = 1'b0;
        bus.clr_cnt_i = 1'b0;
        repeat (3) step();
        check_outs("reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        step();

        // 1. Short press with two ticks.
        bus.db_i = 1'b1;
        step();
        check_outs("t1.rise", 1, 0, 0, 1, 0, 0);
        step();
        check_outs("t1.hold", 0, 0, 0, 1, 0, 0);
        tick();
        tick();
        check("t1.nolong", 32'(bus.long_press_o), 32'd0);
        bus.db_i = 1'b0;
        step();
        check_outs("t1.fall", 0, 1, 0, 0, 1, 0);
        step();
        check_outs("t1.idle", 0, 0, 0, 0, 1, 0);
        check("t1.long_seen", 32'(long_seen), 32'd0);

        // 2. Long press: five ticks, the fifth ignored.
        clear_counters();
        check("t2.clr", 32'(bus.press_cnt_o), 32'd0);
        bus.db_i = 1'b1;
        step();
        check("t2.rise", 32'(bus.rise_tick_o), 32'd1);
        for (int i = 0; i < LT - 1; i++) begin
            tick();
            check("t2.pre", 32'(bus.long_press_o), 32'd0);
        end
        tick();
        check_outs("t2.long", 0, 0, 1, 1, 0, 1);
        step();
        check("t2.long_off", 32'(bus.long_press_o), 32'd0);
        l0 = long_seen;
        tick();
        step();
        check("t2.5th_ign", 32'(long_seen), 32'(l0));
        check("t2.5th_cnt", 32'(bus.long_cnt_o), 32'd1);
        bus.db_i = 1'b0;
        step();
        check_outs("t2.fall", 0, 1, 0, 0, 0, 1);

        // 3. Release races the threshold tick: release wins.
        clear_counters();
        check("t3.clr", 32'(bus.long_cnt_o), 32'd0);
        bus.db_i = 1'b1;
        step();
        for (int i = 0; i < LT - 1; i++) tick();
        l0 = long_seen;
        bus.db_i     = 1'b0;
        bus.m_tick_i = 1'b1;
        step();
        bus.m_tick_i = 1'b0;
        check_outs("t3.race", 0, 1, 0, 0, 1, 0);
        step();
        check("t3.nolong", 32'(long_seen), 32'(l0));

        // 4. Saturation, then a clear colliding with a release.
        clear_counters();
        f0 = fall_seen;
        for (int i = 1; i <= 17; i++) begin
            bus.db_i = 1'b1;
            step();
            step();
            bus.db_i = 1'b0;
            step();
            step();
            if (i == 15) check("t4.at15", 32'(bus.press_cnt_o), 32'd15);
        end
        check("t4.sat", 32'(bus.press_cnt_o), 32'd15);
        check("t4.falls", 32'(fall_seen - f0), 32'd17);
        bus.db_i = 1'b1;
        step();
        step();
        bus.db_i      = 1'b0;
        bus.clr_cnt_i = 1'b1;
        step();
        bus.clr_cnt_i = 1'b0;
        check_outs("t4.clr_fall", 0, 1, 0, 0, 0, 0);

        // 5. Reset while in LONG with db held high.
        step();
        bus.db_i = 1'b1;
        step();
        for (int i = 0; i < LT; i++) tick();
        check("t5.long", 32'(bus.long_press_o), 32'd1);
        check("t5.lcnt", 32'(bus.long_cnt_o), 32'd1);
        reset = 1'b0;
        #1;
        check_outs("t5.async", 0, 0, 0, 0, 0, 0);
        step();
        step();
        check_outs("t5.inrst", 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        r0 = rise_seen;
        step();
        check_outs("t5.rise", 1, 0, 0, 1, 0, 0);
        // Hold counter restarted: threshold needs exactly LT fresh ticks.
        for (int i = 0; i < LT - 1; i++) begin
            tick();
            check("t5.pre", 32'(bus.long_press_o), 32'd0);
        end
        tick();
        check_outs("t5.long2", 0, 0, 1, 1, 0, 1);
        check("t5.rise_cnt", 32'(rise_seen - r0), 32'd1);
        bus.db_i = 1'b0;
        step();
        check_outs("t5.fall", 0, 1, 0, 0, 0, 1);
        step();

        // 6. Ticks while idle do nothing.
        r0 = rise_seen;
        f0 = fall_seen;
        l0 = long_seen;
        for (int i = 0; i < 50; i++) begin
            tick();
            step();
        end
        check_outs("t6.idle", 0, 0, 0, 0, 0, 1);
        check("t6.rise", 32'(rise_seen), 32'(r0));
        check("t6.fall", 32'(fall_seen), 32'(f0));
        check("t6.long", 32'(long_seen), 32'(l0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_db_event_detect
